// File: rtl/stack_call_ctrl.sv
// stack_call_ctrl: sequencer for the 2-level return stack of a PIC16C57-style core.
// Converts decoded CALL / return requests into a one-cycle stack command followed
// by a one-cycle PC load strobe, and tracks stack depth with sticky
// overflow/underflow flags.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for call_req / ret_req, busy low
//   PUSH  | stack_op=PUSH with the captured return address on stack_in
//   POP   | stack_op=POP, pre-pop stack_top is captured into pc_next
//   LOAD  | pc_load strobe, PC takes pc_next
module stack_call_ctrl #(
  parameter int         ADDR_W  = 11,
  parameter logic [1:0] OP_PUSH = 2'd0,
  parameter logic [1:0] OP_POP  = 2'd1,
  parameter logic [1:0] OP_NONE = 2'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] call_target,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] stack_top,
  input  logic              clr_flags,
  output logic [1:0]        stack_op,
  output logic [ADDR_W-1:0] stack_in,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              busy,
  output logic [1:0]        depth,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] tgt;

  // Single registered FSM: outputs are set for the state being entered, so
  // nothing downstream ever sees a path from the request inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stack_op  <= OP_NONE;
      stack_in  <= '0;
      pc_load   <= 1'b0;
      pc_next   <= '0;
      busy      <= 1'b0;
      depth     <= 2'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      tgt       <= '0;
    end else begin
      // Clear first; a set later in this block overrides it for the same edge.
      if (clr_flags) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          stack_op <= OP_NONE;
          pc_load  <= 1'b0;
          busy     <= 1'b0;
          if (call_req) begin
            // Return address wraps naturally at the top of program memory.
            stack_in <= pc + ADDR_W'(1);
            tgt      <= call_target;
            stack_op <= OP_PUSH;
            busy     <= 1'b1;
            state    <= PUSH;
          end else if (ret_req) begin
            stack_op <= OP_POP;
            busy     <= 1'b1;
            state    <= POP;
          end
        end

        PUSH: begin
          // At full depth the stack silently drops its oldest entry.
          if (depth == 2'd2) begin
            overflow <= 1'b1;
          end else begin
            depth <= depth + 2'd1;
          end
          pc_next  <= tgt;
          stack_op <= OP_NONE;
          pc_load  <= 1'b1;
          busy     <= 1'b1;
          state    <= LOAD;
        end

        POP: begin
          // stack_top still shows the pre-pop entry at this edge; on an empty
          // stack the stale value is loaded anyway, matching the real part.
          pc_next <= stack_top;
          if (depth == 2'd0) begin
            underflow <= 1'b1;
          end else begin
            depth <= depth - 2'd1;
          end
          stack_op <= OP_NONE;
          pc_load  <= 1'b1;
          busy     <= 1'b1;
          state    <= LOAD;
        end

        LOAD: begin
          stack_op <= OP_NONE;
          pc_load  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          stack_op <= OP_NONE;
          pc_load  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_call_ctrl.sv
// tb_stack_call_ctrl: scoreboard bench for stack_call_ctrl with a behavioural
// 2-level stack driving stack_top.
module tb_stack_call_ctrl;
  localparam int         ADDR_W  = 11;
  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_NONE = 2'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              call_req = 1'b0;
  logic              ret_req = 1'b0;
  logic [ADDR_W-1:0] call_target = '0;
  logic [ADDR_W-1:0] pc = '0;
  logic [ADDR_W-1:0] stack_top;
  logic              clr_flags = 1'b0;
  logic [1:0]        stack_op;
  logic [ADDR_W-1:0] stack_in;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              busy;
  logic [1:0]        depth;
  logic              overflow;
  logic              underflow;

  stack_call_ctrl #(
    .ADDR_W (ADDR_W),
    .OP_PUSH(OP_PUSH),
    .OP_POP (OP_POP),
    .OP_NONE(OP_NONE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .call_req   (call_req),
    .ret_req    (ret_req),
    .call_target(call_target),
    .pc         (pc),
    .stack_top  (stack_top),
    .clr_flags  (clr_flags),
    .stack_op   (stack_op),
    .stack_in   (stack_in),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .busy       (busy),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  // Behavioural 2-level hardware stack, reset by the same rst.
  logic [ADDR_W-1:0] lvl1, lvl2;
  assign stack_top = lvl1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl1 <= '0;
      lvl2 <= '0;
    end else if (stack_op == OP_PUSH) begin
      lvl2 <= lvl1;
      lvl1 <= stack_in;
    end else if (stack_op == OP_POP) begin
      lvl1 <= lvl2;
    end
  end

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] din;
  } op_t;

  typedef struct {
    logic [ADDR_W-1:0] pcn;
    logic [1:0]        dep;
    logic              ovf;
    logic              unf;
  } load_t;

  op_t   op_q[$];
  load_t load_q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state of the sequencer as seen from outside.
  logic [ADDR_W-1:0] es0 = '0, es1 = '0;
  logic [1:0]        m_depth = 2'd0;
  logic              m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: every stack command and every pc_load must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (stack_op != OP_NONE) begin
        if (op_q.size() == 0) begin
          chk("unexpected_op", 32'(stack_op), 32'(OP_NONE));
        end else begin
          op_t e;
          e = op_q.pop_front();
          chk("stack_op", 32'(stack_op), 32'(e.op));
          if (e.op == OP_PUSH) chk("stack_in", 32'(stack_in), 32'(e.din));
          chk("busy_cmd", 32'(busy), 32'd1);
          chk("no_load_in_cmd", 32'(pc_load), 32'd0);
        end
      end
      if (pc_load) begin
        if (load_q.size() == 0) begin
          chk("extra_load", 32'(pc_load), 32'd0);
        end else begin
          load_t l;
          l = load_q.pop_front();
          chk("pc_next", 32'(pc_next), 32'(l.pcn));
          chk("depth", 32'(depth), 32'(l.dep));
          chk("overflow", 32'(overflow), 32'(l.ovf));
          chk("underflow", 32'(underflow), 32'(l.unf));
          chk("busy_load", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    call_req = 1'b0;
    ret_req = 1'b0;
    clr_flags = 1'b0;
    op_q.delete();
    load_q.delete();
    es0 = '0;
    es1 = '0;
    m_depth = 2'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_call(input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] t,
                         input bit clr, input int hold, input bit both);
    logic [ADDR_W-1:0] ra;
    logic              set;
    wait_idle();
    ra  = p + 11'd1;
    set = (m_depth == 2'd2);
    call_req = 1'b1;
    ret_req = both;
    pc = p;
    call_target = t;
    clr_flags = clr;
    op_q.push_back('{OP_PUSH, ra});
    if (!set) m_depth = m_depth + 2'd1;
    m_ovf = set | (m_ovf & ~clr);
    m_unf = m_unf & ~clr;
    load_q.push_back('{t, m_depth, m_ovf, m_unf});
    es1 = es0;
    es0 = ra;
    repeat (hold) @(negedge clk);
    call_req = 1'b0;
    ret_req = 1'b0;
    wait_idle();
    if (clr) begin
      clr_flags = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
  endtask

  task automatic do_ret();
    logic set;
    wait_idle();
    set = (m_depth == 2'd0);
    ret_req = 1'b1;
    op_q.push_back('{OP_POP, '0});
    if (!set) m_depth = m_depth - 2'd1;
    m_unf = m_unf | set;
    load_q.push_back('{es0, m_depth, m_ovf, m_unf});
    es0 = es1;
    @(negedge clk);
    ret_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held.
    #12;
    chk("rst_stack_op", 32'(stack_op), 32'(OP_NONE));
    chk("rst_stack_in", 32'(stack_in), 32'd0);
    chk("rst_pc_load", 32'(pc_load), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Basic call then return.
    do_reset();
    do_call(11'h010, 11'h200, 1'b0, 1, 1'b0);
    do_ret();

    // Three calls overflow the 2-level stack; two returns unwind.
    do_reset();
    do_call(11'h100, 11'h300, 1'b0, 1, 1'b0);
    do_call(11'h101, 11'h301, 1'b0, 1, 1'b0);
    do_call(11'h102, 11'h302, 1'b0, 1, 1'b0);
    do_ret();
    do_ret();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Overflow set coincident with clr_flags: set wins, then clears.
    do_reset();
    do_call(11'h020, 11'h040, 1'b0, 1, 1'b0);
    do_call(11'h021, 11'h041, 1'b0, 1, 1'b0);
    do_call(11'h022, 11'h042, 1'b1, 1, 1'b0);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Return on empty stack.
    do_reset();
    do_ret();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    m_unf = 1'b0;
    chk("unf_cleared", 32'(underflow), 32'd0);

    // Simultaneous call/ret with PC wrap; requests held through busy.
    do_reset();
    do_call(11'h7FF, 11'h005, 1'b0, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("both_depth", 32'(depth), 32'd1);

    // Reset during PUSH abandons the sequence.
    do_reset();
    wait_idle();
    call_req = 1'b1;
    pc = 11'h050;
    call_target = 11'h123;
    op_q.push_back('{OP_PUSH, 11'h051});
    @(negedge clk);
    call_req = 1'b0;
    #2;
    chk("push_seen", 32'(op_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_stack_op", 32'(stack_op), 32'(OP_NONE));
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc_load", 32'(pc_load), 32'd0);
    chk("mid_rst_pc_next", 32'(pc_next), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_depth", 32'(depth), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("op_q_drained", 32'(op_q.size()), 32'd0);
    chk("load_q_drained", 32'(load_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_call_ctrl.md
Name: stack_call_ctrl

Overview:
- Sequencer for the 2-level 11-bit hardware return stack used by the PIC16C57 core.
- Turns decoded CALL and RETLW/return requests into timed stack PUSH/POP commands and program-counter load strobes.
- Tracks stack depth and raises sticky overflow/underflow flags.
- Sits between the instruction decoder, the PC register and the stack.

Parameters:
- ADDR_W, 11, program address width; must match the stack data width.
- OP_PUSH, 2'd0, stack command code for push.
- OP_POP, 2'd1, stack command code for pop.
- OP_NONE, 2'd2, stack command code for no operation.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- call_req  input  1  decoder request for CALL; sampled only when busy=0.
- ret_req  input  1  decoder request for return/RETLW; sampled only when busy=0.
- call_target  input  ADDR_W  CALL destination address; captured with call_req.
- pc  input  ADDR_W  current PC value; captured with call_req.
- stack_top  input  ADDR_W  stack level-1 output, i.e. the current top.
- clr_flags  input  1  synchronous clear of overflow and underflow.
- stack_op  output  2  command to the stack.
- stack_in  output  ADDR_W  push data (return address) to the stack.
- pc_load  output  1  one-cycle strobe: PC takes pc_next.
- pc_next  output  ADDR_W  address to load into the PC.
- busy  output  1  high while a request is being sequenced.
- depth  output  2  number of valid stack entries, 0..2.
- overflow  output  1  sticky: a CALL was made with depth=2.
- underflow  output  1  sticky: a return was made with depth=0.

Behaviour:
- Reset values (rst=1, asynchronous, any state):
  - state=IDLE, stack_op=OP_NONE, stack_in=0, pc_load=0, pc_next=0.
  - busy=0, depth=0, overflow=0, underflow=0.
  - Reset mid-sequence abandons the sequence; no pc_load is issued. The stack is reset by the same rst.
- State machine: IDLE, PUSH, POP, LOAD. All outputs are registered or decoded from state only, never from request inputs.
- IDLE:
  - busy=0, stack_op=OP_NONE.
  - If call_req=1: capture ret_addr=(pc+1) mod 2^ADDR_W (0x7FF wraps to 0x000), capture tgt=call_target, go to PUSH.
  - Else if ret_req=1: go to POP.
  - call_req has priority when both are high; the ret_req is dropped, not queued.
- PUSH (1 cycle):
  - stack_op=OP_PUSH, stack_in=ret_addr, busy=1.
  - At the edge: if depth=2, set overflow and keep depth=2 (oldest entry is lost); else depth+1. pc_next<=tgt. Go to LOAD.
- POP (1 cycle):
  - stack_op=OP_POP, busy=1.
  - At the same edge as the pop: pc_next<=stack_top, sampling the pre-pop top.
  - If depth=0, set underflow and keep depth=0; pc_next still takes the stale stack_top. Else depth-1. Go to LOAD.
- LOAD (1 cycle):
  - stack_op=OP_NONE, pc_load=1, busy=1. Go to IDLE.
- Latency: request accepted at edge N, stack command during cycle N+1, pc_load during cycle N+2. A new request can be accepted at edge N+3 at the earliest.
- Requests asserted while busy=1 are ignored; the decoder must hold or re-issue them.
- stack_in is held at the last ret_addr outside PUSH; its value is don't-care there.
- pc_load is low in every state except LOAD.
- clr_flags: clears overflow and underflow at the next edge. If a set event occurs in the same cycle, the set wins.
- depth never exceeds 2 and never wraps below 0.

Test Plan:
- Reset then CALL with pc=0x010, call_target=0x200:
  - Next cycle: stack_op=0, stack_in=0x011.
  - Following cycle: pc_load=1, pc_next=0x200, depth=1.
- After the CALL above, return request with stack_top=0x011:
  - Next cycle: stack_op=1.
  - Following cycle: pc_load=1, pc_next=0x011, depth=0, underflow=0.
- Three CALLs from pc=0x100, 0x101, 0x102:
  - depth goes 1, 2, 2; overflow=1 after the third PUSH.
  - Two returns then yield pc_next=0x103, then 0x102.
- Return request at depth=0 with stack_top=0x000:
  - underflow=1, depth=0, pc_next=0x000, pc_load pulses.
  - Then clr_flags=1 -> underflow=0 the next cycle.
- call_req and ret_req high together with pc=0x7FF, call_target=0x005:
  - Only PUSH occurs, with stack_in=0x000 (wrap), then pc_next=0x005; no POP.
  - A second call_req while busy=1 is ignored (exactly one PUSH).
- rst asserted during the PUSH state of a CALL:
  - Outputs return immediately to reset values; no pc_load follows; depth=0.
